// File: rtl/fp_div_pkg.sv
// Shared types and sizing for the significand divider.
// Optional build macro: FP_DIV_EARLY_TERM_EN (stop early on zero remainder).
package fp_div_pkg;

  localparam int MANT_W = 24;
  localparam int Q_W    = MANT_W + 2;
  localparam int CNT_W  = $clog2(Q_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/fp_mantissa_divider_prefix_subtractor.sv
// Kogge-Stone kgp-prefix subtractor: diff = a - b, carry-in fixed at 1.
// Optional build macro: none.
module prefix_subtractor #(
  parameter int W = 26
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  localparam int L = $clog2(W);

  logic [W-1:0] bb;
  logic [W-1:0] p0;
  logic [W-1:0] gc;
  logic [W-1:0] pc;
  logic [W-1:0] gn;
  logic [W-1:0] pn;
  logic [W-1:0] carry;

  assign bb = ~b;

  always_comb begin
    p0 = a ^ bb;
    pc = p0;
    gc = a & bb;
    // Fold the carry-in of 1 into bit 0 generate
    gc[0] = a[0] | bb[0];
    gn = gc;
    pn = pc;
    for (int lv = 0; lv < L; lv++) begin
      gn = gc;
      pn = pc;
      for (int i = (1 << lv); i < W; i++) begin
        gn[i] = gc[i] | (pc[i] & gc[i-(1<<lv)]);
        pn[i] = pc[i] & pc[i-(1<<lv)];
      end
      gc = gn;
      pc = pn;
    end
  end

  assign carry  = {gc[W-2:0], 1'b1};
  assign diff   = p0 ^ carry;
  assign borrow = ~gc[W-1];

endmodule

// File: rtl/fp_mantissa_divider.sv
// Radix-2 restoring divider for normalised significands, one bit per cycle.
// Optional build macro: FP_DIV_EARLY_TERM_EN.
module fp_mantissa_divider
  import fp_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] dividend,
  input  logic [MANT_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Q_W-1:0]    quotient,
  output logic              sticky,
  output logic              div_zero
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(Q_W - 1);

  div_state_t        state;
  logic [MANT_W-1:0] dvsr;
  logic [Q_W-1:0]    rem;
  logic [Q_W-1:0]    rem_nxt;
  logic [Q_W-1:0]    diff;
  logic              borrow;
  logic [Q_W-1:0]    q_nxt;
  logic [CNT_W-1:0]  count;

  prefix_subtractor #(.W(Q_W)) u_sub (
    .a      (rem),
    .b      ({2'b00, dvsr}),
    .diff   (diff),
    .borrow (borrow)
  );

  assign rem_nxt = borrow ? (rem << 1) : (diff << 1);
  assign q_nxt   = {quotient[Q_W-2:0], ~borrow};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      sticky    <= 1'b0;
      div_zero  <= 1'b0;
      rem       <= '0;
      dvsr      <= '0;
      count     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            dvsr     <= divisor;
            rem      <= {2'b00, dividend};
            count    <= '0;
            in_ready <= 1'b0;
            sticky   <= 1'b0;
            if (divisor == '0) begin
              div_zero  <= 1'b1;
              quotient  <= '1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              div_zero <= 1'b0;
              quotient <= '0;
              state    <= BUSY;
            end
          end
        end
        BUSY: begin
          rem      <= rem_nxt;
          quotient <= q_nxt;
          count    <= count + 1'b1;
          if (count == LAST) begin
            sticky    <= |rem_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
`ifdef FP_DIV_EARLY_TERM_EN
          else if (rem_nxt == '0) begin
            // Remaining quotient bits are all zero; pad them in now
            quotient  <= q_nxt << (LAST - count);
            sticky    <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
